// File: rtl/consul_pkg.sv
// Shared definitions for the typewriter console controller: FSM state
// encodings, sense/drive line bit positions and fixed typewriter codes.
package consul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      STROBE,
      WAIT_ACK
   } printState_t;

   typedef enum logic [1:0] {
      KB_IDLE,
      KB_WAIT,
      KB_RELEASE
   } kbState_t;

   // What the print FSM is currently sending to the typewriter
   typedef enum logic [1:0] {
      KIND_CHAR,
      KIND_NL,
      KIND_REG
   } printKind_t;

   // regs_in bit positions
   localparam int IN_CODE_MSB     = 6;
   localparam int IN_PARITY_FLAG  = 7;
   localparam int IN_NEED_NL      = 8;
   localparam int IN_BLOCK_PRINT  = 9;
   localparam int IN_IS_MOVING    = 10;
   localparam int IN_HIGH_REG     = 11;
   localparam int IN_CO_ACQ       = 12;
   localparam int IN_RED_PRINT    = 13;
   localparam int IN_TOP_SYM      = 14;
   localparam int IN_CIN_READY    = 15;

   // regs_out bit positions
   localparam int OUT_CODE_MSB    = 6;
   localparam int OUT_SYNC        = 7;
   localparam int OUT_SET_TAB     = 8;
   localparam int OUT_SET_KB_BLK  = 9;

   // Carriage return and register-switch code base
   localparam logic [6:0] CODE_CR       = 7'h0D;
   localparam logic [5:0] CODE_REG_BASE = 6'b000111;

   // Code that switches the typewriter into the requested register
   function automatic logic [6:0] regSwitchCode(input logic upper);
      return {CODE_REG_BASE, upper};
   endfunction

endpackage

// File: rtl/consul_fifo.sv
// Small synchronous FIFO holding characters waiting to be printed.
// Pushes while full are dropped; pops while empty are ignored.
module consul_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_pushOk;
   logic             w_popOk;

   assign o_full   = (r_count == FULL_COUNT);
   assign o_empty  = (r_count == '0);
   assign w_pushOk = i_push && !o_full;
   assign w_popOk  = i_pop && !o_empty;
   assign o_data   = r_mem[r_rdPtr];

   // Storage array is written only on accepted pushes and needs no reset
   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_pushOk, w_popOk})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/consul_ctrl.sv
// Console controller for an electromechanical typewriter: buffers output
// characters, sequences code/settle/sync/acknowledge for each print, handles
// newline and register-switch insertion, and captures keyboard characters.
module consul_ctrl
   import consul_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [7:0]  stdout,
   input  logic        Cout,
   output logic        CoutFull,
   input  logic        CinReq,
   output logic [7:0]  stdin,
   output logic        CinValid,
   input  logic [15:0] regs_in,
   output logic [9:0]  regs_out,
   output logic        Timeout,
   input  logic        ErrClr
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [15:0]   r_regsIn;
   logic          w_unusedRedPrint;

   logic [7:0]    w_head;
   logic          w_empty;
   logic          w_pop;

   printState_t   r_state;
   printState_t   w_stateNext;
   printKind_t    r_kind;
   printKind_t    w_kindNext;
   logic [6:0]    r_out;
   logic [6:0]    w_outNext;
   logic          r_sync;
   logic          w_syncNext;
   logic [SW-1:0] r_settleCnt;
   logic [SW-1:0] w_settleNext;
   logic [TW-1:0] r_ackCnt;
   logic [TW-1:0] w_ackNext;
   logic          w_done;
   logic          w_timeoutSet;
   logic          r_timeout;

   kbState_t      r_kbState;
   kbState_t      w_kbNext;
   logic          r_kbBlock;
   logic          w_kbBlockNext;
   logic [7:0]    r_stdin;
   logic [7:0]    w_stdinNext;
   logic          r_cinValid;
   logic          w_cinValidNext;
   logic          w_parityOk;

   assign w_unusedRedPrint = r_regsIn[IN_RED_PRINT];

   consul_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (Clk),
      .i_rst   (Rst),
      .i_push  (Cout),
      .i_data  (stdout),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (CoutFull),
      .o_empty (w_empty)
   );

   // Sense lines come from a slow mechanical device; register them once
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_regsIn <= '0;
      end else begin
         r_regsIn <= regs_in;
      end
   end

   // Print FSM next state: pick a code, let the relays settle, strobe, wait
   always_comb begin
      w_stateNext  = r_state;
      w_kindNext   = r_kind;
      w_outNext    = r_out;
      w_settleNext = r_settleCnt;
      w_ackNext    = r_ackCnt;
      w_pop        = 1'b0;
      w_timeoutSet = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty &&
                (!r_regsIn[IN_IS_MOVING] || !r_regsIn[IN_BLOCK_PRINT])) begin
               w_stateNext = LOAD;
            end
         end
         LOAD: begin
            if (r_regsIn[IN_NEED_NL]) begin
               w_kindNext = KIND_NL;
               w_outNext  = CODE_CR;
            end else if (r_regsIn[IN_HIGH_REG] != w_head[7]) begin
               w_kindNext = KIND_REG;
               w_outNext  = regSwitchCode(w_head[7]);
            end else begin
               w_kindNext = KIND_CHAR;
               w_outNext  = w_head[6:0];
            end
            w_settleNext = '0;
            w_stateNext  = SETTLE;
         end
         SETTLE: begin
            if (r_settleCnt == SETTLE_LAST) begin
               w_stateNext = STROBE;
            end else begin
               w_settleNext = r_settleCnt + 1'b1;
            end
         end
         STROBE: begin
            w_ackNext   = '0;
            w_stateNext = WAIT_ACK;
         end
         WAIT_ACK: begin
            case (r_kind)
               KIND_NL:  w_done = !r_regsIn[IN_IS_MOVING];
               KIND_REG: w_done = (r_regsIn[IN_HIGH_REG] == w_head[7]);
               default:  w_done = r_regsIn[IN_CO_ACQ];
            endcase
            if (w_done) begin
               w_pop       = (r_kind == KIND_CHAR);
               w_stateNext = IDLE;
            end else if (r_ackCnt == TIMEOUT_LAST) begin
               w_pop        = (r_kind == KIND_CHAR);
               w_timeoutSet = 1'b1;
               w_stateNext  = IDLE;
            end else begin
               w_ackNext = r_ackCnt + 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
      w_syncNext = (w_stateNext == STROBE) || (w_stateNext == WAIT_ACK);
   end

   // Print FSM registers; sync tracks the strobe/wait states of the next cycle
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= IDLE;
         r_kind      <= KIND_CHAR;
         r_out       <= '0;
         r_sync      <= 1'b0;
         r_settleCnt <= '0;
         r_ackCnt    <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_kind      <= w_kindNext;
         r_out       <= w_outNext;
         r_sync      <= w_syncNext;
         r_settleCnt <= w_settleNext;
         r_ackCnt    <= w_ackNext;
      end
   end

   // Sticky timeout flag; a fresh timeout beats a simultaneous clear
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_timeout <= 1'b0;
      end else if (w_timeoutSet) begin
         r_timeout <= 1'b1;
      end else if (ErrClr) begin
         r_timeout <= 1'b0;
      end
   end

   assign w_parityOk = r_regsIn[IN_PARITY_FLAG] && (^r_regsIn[IN_CODE_MSB:0]);

   // Keyboard FSM next state: unblock on request, capture once per keystroke
   always_comb begin
      w_kbNext       = r_kbState;
      w_kbBlockNext  = r_kbBlock;
      w_stdinNext    = r_stdin;
      w_cinValidNext = 1'b0;
      case (r_kbState)
         KB_IDLE: begin
            if (CinReq) begin
               w_kbBlockNext = 1'b0;
               w_kbNext      = KB_WAIT;
            end
         end
         KB_WAIT: begin
            if (!CinReq) begin
               w_kbBlockNext = 1'b1;
               w_kbNext      = KB_IDLE;
            end else if (r_regsIn[IN_CIN_READY] && w_parityOk) begin
               w_stdinNext    = {r_regsIn[IN_TOP_SYM], r_regsIn[IN_CODE_MSB:0]};
               w_cinValidNext = 1'b1;
               w_kbBlockNext  = 1'b1;
               w_kbNext       = KB_RELEASE;
            end
         end
         KB_RELEASE: begin
            if (!r_regsIn[IN_CIN_READY]) begin
               w_kbNext = KB_IDLE;
            end
         end
         default: begin
            w_kbBlockNext = 1'b1;
            w_kbNext      = KB_IDLE;
         end
      endcase
   end

   // Keyboard FSM registers; the keyboard starts out blocked
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_kbState  <= KB_IDLE;
         r_kbBlock  <= 1'b1;
         r_stdin    <= '0;
         r_cinValid <= 1'b0;
      end else begin
         r_kbState  <= w_kbNext;
         r_kbBlock  <= w_kbBlockNext;
         r_stdin    <= w_stdinNext;
         r_cinValid <= w_cinValidNext;
      end
   end

   assign regs_out[OUT_CODE_MSB:0]  = r_out;
   assign regs_out[OUT_SYNC]        = r_sync;
   assign regs_out[OUT_SET_TAB]     = 1'b0;
   assign regs_out[OUT_SET_KB_BLK]  = r_kbBlock;
   assign stdin                     = r_stdin;
   assign CinValid                  = r_cinValid;
   assign Timeout                   = r_timeout;

endmodule

// File: tb/tb_consul_ctrl.sv
// Directed bench for the console controller: printing, register switch,
// newline insertion, FIFO overflow, timeout, mid-print reset and keyboard.
module tb_consul_ctrl;

   localparam int DEPTH  = 4;
   localparam int SETTLE = 6;
   localparam int TMO    = 40;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [7:0]  stdout;
   logic        Cout;
   logic        CoutFull;
   logic        CinReq;
   logic [7:0]  stdin;
   logic        CinValid;
   logic [15:0] regs_in;
   logic [9:0]  regs_out;
   logic        Timeout;
   logic        ErrClr;

   int nChecks = 0;
   int nFails  = 0;

   consul_ctrl #(
      .FIFO_DEPTH     (DEPTH),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .stdout   (stdout),
      .Cout     (Cout),
      .CoutFull (CoutFull),
      .CinReq   (CinReq),
      .stdin    (stdin),
      .CinValid (CinValid),
      .regs_in  (regs_in),
      .regs_out (regs_out),
      .Timeout  (Timeout),
      .ErrClr   (ErrClr)
   );

   // Free-running system clock
   always #5 Clk = ~Clk;

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushChar(input logic [7:0] c);
      stdout = c;
      Cout   = 1'b1;
      @(negedge Clk);
      Cout   = 1'b0;
   endtask

   task automatic pulseAck();
      regs_in[12] = 1'b1;
      @(negedge Clk);
      regs_in[12] = 1'b0;
   endtask

   task automatic waitSync(input logic val, input int bound, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (regs_out[7] === val) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
   endtask

   task automatic countSyncs(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clk);
         if (regs_out[7] === 1'b1) seen++;
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; stdout = '0; Cout = 1'b0; CinReq = 1'b0;
      regs_in = '0; ErrClr = 1'b0;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      nChecks++;
      if (regs_out !== 10'h200) begin
         nFails++;
         $display("[TB] FAIL reset_regs_out: got %h expected %h", regs_out, 10'h200);
      end
      nChecks++;
      if ({stdin, CinValid, Timeout, CoutFull} !== 11'h000) begin
         nFails++;
         $display("[TB] FAIL reset_outputs: got stdin=%h valid=%b tmo=%b full=%b expected all 0",
                  stdin, CinValid, Timeout, CoutFull);
      end
   endtask

   task automatic test_basic_char();
      logic ok;
      int   cnt;
      int   seen;
      pushChar(8'h41);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (regs_out[6:0] === 7'h41) begin ok = 1'b1; break; end
         @(negedge Clk);
      end
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL basic_out_appears: got out=%h expected 41", regs_out[6:0]);
      end
      cnt = 0;
      while (regs_out[7] === 1'b0 && regs_out[6:0] === 7'h41 && cnt < 100) begin
         cnt++;
         @(negedge Clk);
      end
      nChecks++;
      if (cnt != SETTLE) begin
         nFails++;
         $display("[TB] FAIL basic_settle_len: got %0d cycles expected %0d", cnt, SETTLE);
      end
      nChecks++;
      if (regs_out[7:0] !== 8'hC1) begin
         nFails++;
         $display("[TB] FAIL basic_strobe: got sync/out=%h expected c1", regs_out[7:0]);
      end
      pulseAck();
      waitSync(1'b0, 5, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL basic_sync_drop: got sync=%b expected 0", regs_out[7]);
      end
      countSyncs(SETTLE + 6, seen);
      nChecks++;
      if (seen != 0 || CoutFull !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL basic_fifo_empty: got %0d sync cycles full=%b expected 0/0", seen, CoutFull);
      end
   endtask

   task automatic test_reg_switch();
      logic ok;
      pushChar(8'hC1);
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok || regs_out[6:0] !== 7'h0F) begin
         nFails++;
         $display("[TB] FAIL reg_switch_code: got sync=%b out=%h expected 1/0f", regs_out[7], regs_out[6:0]);
      end
      regs_in[11] = 1'b1;
      waitSync(1'b0, 6, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL reg_switch_done: got sync=%b expected 0", regs_out[7]);
      end
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok || regs_out[6:0] !== 7'h41) begin
         nFails++;
         $display("[TB] FAIL reg_switch_char: got sync=%b out=%h expected 1/41", regs_out[7], regs_out[6:0]);
      end
      pulseAck();
      waitSync(1'b0, 5, ok);
      regs_in[11] = 1'b0;
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL reg_switch_ack: got sync=%b expected 0", regs_out[7]);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_newline();
      logic ok;
      regs_in[8]  = 1'b1;
      regs_in[10] = 1'b1;
      pushChar(8'h42);
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok || regs_out[6:0] !== 7'h0D) begin
         nFails++;
         $display("[TB] FAIL newline_code: got sync=%b out=%h expected 1/0d", regs_out[7], regs_out[6:0]);
      end
      regs_in[8]  = 1'b0;
      regs_in[10] = 1'b0;
      waitSync(1'b0, 6, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL newline_done: got sync=%b expected 0", regs_out[7]);
      end
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok || regs_out[6:0] !== 7'h42) begin
         nFails++;
         $display("[TB] FAIL newline_char: got sync=%b out=%h expected 1/42", regs_out[7], regs_out[6:0]);
      end
      pulseAck();
      waitSync(1'b0, 5, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL newline_ack: got sync=%b expected 0", regs_out[7]);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      logic ok;
      int   seen;
      nChecks++;
      if (CoutFull !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL full_initial: got %b expected 0", CoutFull);
      end
      pushChar(8'h50);
      pushChar(8'h51);
      pushChar(8'h52);
      nChecks++;
      if (CoutFull !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL full_after3: got %b expected 0", CoutFull);
      end
      pushChar(8'h53);
      nChecks++;
      if (CoutFull !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL full_after4: got %b expected 1", CoutFull);
      end
      pushChar(8'h54);
      nChecks++;
      if (CoutFull !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL full_after5: got %b expected 1", CoutFull);
      end
      for (int i = 0; i < 4; i++) begin
         waitSync(1'b1, SETTLE + 10, ok);
         nChecks++;
         if (!ok || regs_out[6:0] !== 7'(8'h50 + i)) begin
            nFails++;
            $display("[TB] FAIL order_char%0d: got sync=%b out=%h expected 1/%h",
                     i, regs_out[7], regs_out[6:0], 7'(8'h50 + i));
         end
         pulseAck();
         waitSync(1'b0, 5, ok);
         nChecks++;
         if (!ok) begin
            nFails++;
            $display("[TB] FAIL order_ack%0d: got sync=%b expected 0", i, regs_out[7]);
         end
      end
      countSyncs(SETTLE + 10, seen);
      nChecks++;
      if (seen != 0 || CoutFull !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL overflow_dropped: got %0d sync cycles full=%b expected 0/0", seen, CoutFull);
      end
   endtask

   task automatic test_mid_reset();
      logic ok;
      int   seen;
      pushChar(8'h61);
      pushChar(8'h62);
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL midreset_start: got sync=%b expected 1", regs_out[7]);
      end
      #2;
      Rst = 1'b1;
      #1;
      nChecks++;
      if (regs_out !== 10'h200) begin
         nFails++;
         $display("[TB] FAIL midreset_async: got %h expected %h", regs_out, 10'h200);
      end
      @(negedge Clk);
      Rst = 1'b0;
      countSyncs(SETTLE + 10, seen);
      nChecks++;
      if (seen != 0 || CoutFull !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL midreset_flush: got %0d sync cycles full=%b expected 0/0", seen, CoutFull);
      end
   endtask

   task automatic test_timeout();
      logic ok;
      int   cnt;
      int   seen;
      pushChar(8'h41);
      waitSync(1'b1, SETTLE + 10, ok);
      nChecks++;
      if (!ok) begin
         nFails++;
         $display("[TB] FAIL timeout_start: got sync=%b expected 1", regs_out[7]);
      end
      cnt = 0;
      while (Timeout !== 1'b1 && cnt < TMO + 20) begin
         cnt++;
         @(negedge Clk);
      end
      nChecks++;
      if (Timeout !== 1'b1 || cnt < TMO || cnt > TMO + 2) begin
         nFails++;
         $display("[TB] FAIL timeout_latency: got tmo=%b after %0d cycles expected 1 after %0d..%0d",
                  Timeout, cnt, TMO, TMO + 2);
      end
      nChecks++;
      if (regs_out[7] !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL timeout_sync: got %b expected 0", regs_out[7]);
      end
      countSyncs(SETTLE + 10, seen);
      nChecks++;
      if (seen != 0 || Timeout !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL timeout_popped: got %0d sync cycles tmo=%b expected 0/1", seen, Timeout);
      end
      ErrClr = 1'b1;
      @(negedge Clk);
      ErrClr = 1'b0;
      nChecks++;
      if (Timeout !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL timeout_clear: got %b expected 0", Timeout);
      end
   endtask

   task automatic test_keyboard();
      int         pulses;
      logic [7:0] got;
      CinReq = 1'b1;
      repeat (2) @(negedge Clk);
      nChecks++;
      if (regs_out[9] !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL kb_unblock: got %b expected 0", regs_out[9]);
      end
      regs_in[7:0] = 8'h83;
      regs_in[15]  = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge Clk);
         if (CinValid === 1'b1) pulses++;
      end
      nChecks++;
      if (pulses != 0) begin
         nFails++;
         $display("[TB] FAIL kb_bad_parity: got %0d pulses expected 0", pulses);
      end
      regs_in[7:0] = 8'h81;
      pulses = 0;
      got = 8'hxx;
      repeat (10) begin
         @(negedge Clk);
         if (CinValid === 1'b1) begin pulses++; got = stdin; end
      end
      nChecks++;
      if (pulses != 1 || got !== 8'h01 || regs_out[9] !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL kb_capture: got %0d pulses stdin=%h blk=%b expected 1/01/1",
                  pulses, got, regs_out[9]);
      end
      regs_in[15]  = 1'b0;
      regs_in[7:0] = 8'h00;
      repeat (4) @(negedge Clk);
      nChecks++;
      if (regs_out[9] !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL kb_rearm: got %b expected 0", regs_out[9]);
      end
      regs_in[14]  = 1'b1;
      regs_in[7:0] = 8'h87;
      regs_in[15]  = 1'b1;
      pulses = 0;
      got = 8'hxx;
      repeat (6) begin
         @(negedge Clk);
         if (CinValid === 1'b1) begin pulses++; got = stdin; end
      end
      nChecks++;
      if (pulses != 1 || got !== 8'h87) begin
         nFails++;
         $display("[TB] FAIL kb_top_symbol: got %0d pulses stdin=%h expected 1/87", pulses, got);
      end
      regs_in[15] = 1'b0;
      regs_in[14] = 1'b0;
      repeat (4) @(negedge Clk);
      CinReq = 1'b0;
      repeat (2) @(negedge Clk);
      nChecks++;
      if (regs_out[9] !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL kb_drop_req: got %b expected 1", regs_out[9]);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      Rst = 1'b1; stdout = '0; Cout = 1'b0; CinReq = 1'b0;
      regs_in = '0; ErrClr = 1'b0;
      @(negedge Clk);
      test_reset();
      test_basic_char();
      test_reg_switch();
      test_newline();
      test_back_to_back();
      test_mid_reset();
      test_timeout();
      test_keyboard();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/consul_ctrl.md
CONSUL_CTRL -- requirements
Module: consul_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output character buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, meaning relay settle delay between code set and sync assert.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max cycles waiting for typewriter acknowledge.
REQ-004 SHALL have port Clk  input  1  the single system clock.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port stdout  input  8  character to print; bit7 is the register (upper/lower) select, bits 6:0 are the code.
REQ-007 SHALL have port Cout  input  1  one-cycle push strobe for stdout.
REQ-008 SHALL have port CoutFull  output  1  output FIFO full.
REQ-009 SHALL have port CinReq  input  1  level request for one keyboard character.
REQ-010 SHALL have port stdin  output  8  received character: {top_symbol_correction, code[6:0]}.
REQ-011 SHALL have port CinValid  output  1  one-cycle pulse when stdin updates.
REQ-012 SHALL have port regs_in  input  16  typewriter sense lines: [7:0] in, [8] need_nl, [9] block_print, [10] is_moving, [11] high_reg, [12] coAcq, [13] red_print (unused), [14] top_symbol_correction, [15] cin_ready.
REQ-013 SHALL have port regs_out  output  10  typewriter drive lines: [6:0] out, [7] sync, [8] set_tab, [9] set_kb_block.
REQ-014 SHALL have port Timeout  output  1  sticky acknowledge-timeout flag.
REQ-015 SHALL have port ErrClr  input  1  clears Timeout.

Function
REQ-016 SHALL register regs_in once (1-cycle sense latency) and register regs_out from internal state.
REQ-017 SHALL push stdout on Cout when not full; a push while full SHALL be dropped, with no FIFO state change.
REQ-018 SHALL support simultaneous push and pop in one cycle when not full, leaving occupancy unchanged.
REQ-019 Print FSM states SHALL be IDLE, LOAD, SETTLE, STROBE, WAIT_ACK.
REQ-020 IDLE->LOAD when FIFO non-empty and (~is_moving | ~block_print).
REQ-021 LOAD: select the code by priority: need_nl -> 0x0D (kind NL); high_reg != head[7] -> {6'b000111, head[7]} (kind REG); else head[6:0] (kind CHAR). Then go to SETTLE.
REQ-022 SETTLE SHALL hold out stable for SETTLE_CYCLES cycles, then go to STROBE.
REQ-023 STROBE SHALL assert sync and go to WAIT_ACK.
REQ-024 WAIT_ACK completion conditions: NL on ~is_moving; REG on high_reg == head[7]; CHAR on coAcq. On completion, deassert sync and return to IDLE.
REQ-025 The FIFO head SHALL pop only on CHAR completion; NL and REG completions leave the head in place.
REQ-026 A cycle counter SHALL run in WAIT_ACK; reaching TIMEOUT_CYCLES SHALL set Timeout, drop sync, pop the head if kind CHAR, and return to IDLE.
REQ-027 ErrClr SHALL clear Timeout; when ErrClr coincides with a new timeout, set SHALL win.
REQ-028 Keyboard FSM states SHALL be KB_IDLE, KB_WAIT, KB_RELEASE, independent of the print FSM.
REQ-029 KB_IDLE->KB_WAIT on CinReq, deasserting set_kb_block.
REQ-030 In KB_WAIT, when cin_ready & in[7] & ^in[6:0]: latch stdin, pulse CinValid, assert set_kb_block, and go to KB_RELEASE.
REQ-031 KB_RELEASE->KB_IDLE when cin_ready is low, so each keystroke is captured exactly once.
REQ-032 CinReq dropping in KB_WAIT SHALL return the FSM to KB_IDLE with set_kb_block asserted.
REQ-033 Characters with invalid parity SHALL be ignored.
REQ-034 set_tab SHALL be held 0.

Reset
REQ-035 On Rst: both FSMs idle, FIFO empty, out=0, sync=0, set_tab=0, set_kb_block=1, stdin=0, CinValid=0, Timeout=0, counters=0.
REQ-036 Rst asserted mid-print SHALL drop sync on that same clock edge and discard all buffered characters.

Structure
REQ-037 Shared package consul_pkg SHALL hold the state enums, the regs_in/regs_out bit-index constants, and the CR and register-switch codes.
REQ-038 The FIFO SHALL be a sub-module consul_fifo, parametrised by width and depth.

Verification
REQ-039 Push 0x41 (high_reg=0) -> out=0x41 held SETTLE_CYCLES cycles, then sync=1; coAcq pulse -> sync=0, FIFO empty.
REQ-040 Push 0xC1 with high_reg=0 -> out=0x0F; raise high_reg -> sync drops, then out=0x41 is printed.
REQ-041 need_nl=1 during head 0x42 -> out=0x0D; is_moving falls -> 0x42 printed next.
REQ-042 Push 5 with FIFO_DEPTH=4 and no acks -> CoutFull=1, 5th push dropped; after 4 acks, exactly 4 characters printed in order.
REQ-043 No coAcq -> Timeout=1 after TIMEOUT_CYCLES, head popped; ErrClr -> Timeout=0.
REQ-044 CinReq=1, in=0x83 (bad parity), then in=0x81 (valid) with cin_ready=1 held 10 cycles -> exactly one CinValid, stdin=0x01.
